// File: rtl/event_ring_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : event_ring_arbiter
// Purpose  : Collects event TRB submissions from NUM_REQ producers into one
//            holding slot each and feeds them, round-robin, to the single
//            event ring writer engine. Owns the engine send/complete
//            handshake and keeps a completed-TRB counter plus a sticky
//            stall flag for debug.
// Ports    : clk_pcie, rst_n            - clock, async active-low reset
//            req_valid/req_ready        - per-producer submit handshake
//            req_interrupter_index      - 3 bits per producer
//            req_trb_data               - 128 bits per producer
//            req_done                   - per-producer completion pulse
//            eng_ready/eng_complete     - engine status inputs
//            eng_send/eng_interrupter_index/eng_trb_data - engine request
//            busy, stall_err, events_issued - status / debug
// Revision : 1.0 - initial release
// ============================================================================
module event_ring_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk_pcie,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_interrupter_index,
    input  logic [128*NUM_REQ-1:0]   req_trb_data,
    output logic [NUM_REQ-1:0]       req_done,
    input  logic                     eng_ready,
    input  logic                     eng_complete,
    output logic                     eng_send,
    output logic [2:0]               eng_interrupter_index,
    output logic [127:0]             eng_trb_data,
    output logic                     busy,
    output logic                     stall_err,
    output logic [31:0]              events_issued
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMO_W = 20;
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CPL = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  slot_full;
    logic [2:0]          slot_idx [NUM_REQ];
    logic [127:0]        slot_trb [NUM_REQ];
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant;
    logic [TMO_W-1:0]    tmo_cnt;

    logic                pick_found;
    logic [PTR_W-1:0]    pick;
    int                  cand;

    // Ready is a pure register decode so producers never see a
    // combinational path from engine or arbitration state.
    assign req_ready = ~slot_full;
    assign busy      = (state != ST_IDLE);

    // Round-robin search starting at rr_ptr over currently full slots only.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        cand       = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = int'(rr_ptr) + j;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_found && slot_full[PTR_W'(cand)]) begin
                pick_found = 1'b1;
                pick       = PTR_W'(cand);
            end
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= ST_IDLE;
            slot_full             <= '0;
            rr_ptr                <= '0;
            grant                 <= '0;
            tmo_cnt               <= '0;
            req_done              <= '0;
            eng_send              <= 1'b0;
            eng_interrupter_index <= '0;
            eng_trb_data          <= '0;
            stall_err             <= 1'b0;
            events_issued         <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_idx[i] <= '0;
                slot_trb[i] <= '0;
            end
        end else begin
            req_done <= '0;

            // Capture into empty slots. A full slot never captures, so the
            // completion clear below cannot collide with a refill.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !slot_full[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_idx[i]  <= req_interrupter_index[3*i +: 3];
                    slot_trb[i]  <= req_trb_data[128*i +: 128];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (eng_ready && pick_found) begin
                        grant                 <= pick;
                        rr_ptr                <= (pick == PTR_LAST) ? '0 : pick + 1'b1;
                        eng_send              <= 1'b1;
                        eng_interrupter_index <= slot_idx[pick];
                        eng_trb_data          <= slot_trb[pick];
                        tmo_cnt               <= '0;
                        state                 <= ST_WAIT_CPL;
                    end
                end

                ST_WAIT_CPL: begin
                    // Stall detection only flags; the request keeps waiting.
                    if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (tmo_cnt == TMO_LAST) begin
                        stall_err <= 1'b1;
                    end
                    if (eng_complete) begin
                        eng_send         <= 1'b0;
                        req_done[grant]  <= 1'b1;
                        slot_full[grant] <= 1'b0;
                        events_issued    <= events_issued + 32'd1;
                        state            <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    // Hold off until the engine has dropped complete and
                    // is idle again, so one completion is never seen twice.
                    if (!eng_complete && eng_ready) begin
                        eng_interrupter_index <= '0;
                        eng_trb_data          <= '0;
                        state                 <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_event_ring_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_ring_arbiter
// Purpose  : Self-checking bench for event_ring_arbiter. A transaction-level
//            model tracks slot occupancy, round-robin order and engine
//            ownership from the observed handshakes; a behavioural engine
//            drives eng_ready/eng_complete with random latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_ring_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TMO     = 16;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_REL  = 2;

    localparam int E_IDLE = 0;
    localparam int E_BUSY = 1;
    localparam int E_CPL  = 2;
    localparam int E_REC  = 3;

    logic                    clk_pcie = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [3*NUM_REQ-1:0]    req_interrupter_index;
    logic [128*NUM_REQ-1:0]  req_trb_data;
    logic [NUM_REQ-1:0]      req_done;
    logic                    eng_ready;
    logic                    eng_complete;
    logic                    eng_send;
    logic [2:0]              eng_interrupter_index;
    logic [127:0]            eng_trb_data;
    logic                    busy;
    logic                    stall_err;
    logic [31:0]             events_issued;

    always #5 clk_pcie = ~clk_pcie;

    event_ring_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_pcie              (clk_pcie),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_interrupter_index (req_interrupter_index),
        .req_trb_data          (req_trb_data),
        .req_done              (req_done),
        .eng_ready             (eng_ready),
        .eng_complete          (eng_complete),
        .eng_send              (eng_send),
        .eng_interrupter_index (eng_interrupter_index),
        .eng_trb_data          (eng_trb_data),
        .busy                  (busy),
        .stall_err             (stall_err),
        .events_issued         (events_issued)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int                  m_phase;
    int                  m_rr;
    int                  m_grant;
    int                  wait_cnt;
    int                  edge_no = 0;
    logic [NUM_REQ-1:0]  m_pending;
    int                  m_cap_edge [NUM_REQ];
    logic [127:0]        m_trb [NUM_REQ];
    logic [2:0]          m_idx [NUM_REQ];
    logic [31:0]         m_events;
    logic                m_stall;
    logic [NUM_REQ-1:0]  obs_ready;
    int                  done_log [$];

    // ---------------- engine model state ----------------
    int e_st, e_cnt;
    int lat_min, lat_max, hold_min, hold_max;
    bit hang;

    task automatic model_reset();
        m_phase   = M_IDLE;
        m_rr      = 0;
        m_grant   = 0;
        wait_cnt  = 0;
        m_pending = '0;
        m_events  = '0;
        m_stall   = 1'b0;
        obs_ready = '1;
        for (int i = 0; i < NUM_REQ; i++) m_cap_edge[i] = 0;
    endtask

    task automatic engine_reset();
        e_st         = E_IDLE;
        e_cnt        = 0;
        eng_ready    = 1'b1;
        eng_complete = 1'b0;
    endtask

    task automatic rand_data(input int i);
        req_interrupter_index[3*i +: 3] = 3'($urandom);
        req_trb_data[128*i +: 128]      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock: advance the model across the edge using the inputs that
    // were sampled there, check every output, then drive the engine.
    task automatic cycle();
        logic [NUM_REQ-1:0] exp_done;
        logic [NUM_REQ-1:0] exp_ready;
        bit found;
        @(negedge clk_pcie);
        edge_no++;
        exp_done = '0;
        found    = 1'b0;
        case (m_phase)
            M_WAIT: begin
                wait_cnt++;
                if (wait_cnt == TMO) m_stall = 1'b1;
                if (eng_complete) begin
                    exp_done[m_grant]  = 1'b1;
                    m_pending[m_grant] = 1'b0;
                    m_events           = m_events + 32'd1;
                    m_phase            = M_REL;
                end
            end
            M_REL: begin
                if (!eng_complete && eng_ready) m_phase = M_IDLE;
            end
            default: begin
                if (eng_ready) begin
                    for (int j = 0; j < NUM_REQ; j++) begin
                        int k;
                        k = (m_rr + j) % NUM_REQ;
                        if (!found && m_pending[k] && m_cap_edge[k] < edge_no) begin
                            found   = 1'b1;
                            m_grant = k;
                        end
                    end
                    if (found) begin
                        m_rr     = (m_grant + 1) % NUM_REQ;
                        m_phase  = M_WAIT;
                        wait_cnt = 0;
                    end
                end
            end
        endcase
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && obs_ready[i]) begin
                m_pending[i]  = 1'b1;
                m_trb[i]      = req_trb_data[128*i +: 128];
                m_idx[i]      = req_interrupter_index[3*i +: 3];
                m_cap_edge[i] = edge_no;
            end
        end
        exp_ready = ~m_pending;

        check("req_done", req_done, exp_done);
        check("req_ready", req_ready, exp_ready);
        check("eng_send", eng_send, m_phase == M_WAIT);
        check("busy", busy, m_phase != M_IDLE);
        check("events_issued", events_issued, m_events);
        check("stall_err", stall_err, m_stall);
        if (m_phase == M_WAIT) begin
            check("eng_trb_data", eng_trb_data, m_trb[m_grant]);
            check("eng_index", eng_interrupter_index, m_idx[m_grant]);
        end else if (m_phase == M_IDLE) begin
            check("idle_trb_data", eng_trb_data, '0);
            check("idle_index", eng_interrupter_index, '0);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_done[i] === 1'b1) done_log.push_back(i);
        end
        obs_ready = req_ready;

        case (e_st)
            E_IDLE: begin
                eng_ready    = 1'b1;
                eng_complete = 1'b0;
                if (eng_send) begin
                    e_st      = E_BUSY;
                    e_cnt     = int'($urandom_range(lat_max, lat_min));
                    eng_ready = 1'b0;
                end
            end
            E_BUSY: begin
                if (!hang) begin
                    if (e_cnt == 0) begin
                        eng_complete = 1'b1;
                        e_cnt        = int'($urandom_range(hold_max, hold_min)) - 1;
                        e_st         = E_CPL;
                    end else begin
                        e_cnt--;
                    end
                end
            end
            E_CPL: begin
                eng_ready = ($urandom_range(1, 0) == 1);
                if (e_cnt == 0) begin
                    eng_complete = 1'b0;
                    eng_ready    = 1'b0;
                    e_cnt        = int'($urandom_range(2, 0));
                    e_st         = E_REC;
                end else begin
                    e_cnt--;
                end
            end
            default: begin
                if (e_cnt == 0) begin
                    eng_ready = 1'b1;
                    e_st      = E_IDLE;
                end else begin
                    e_cnt--;
                end
            end
        endcase
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk_pcie);
        engine_reset();
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        req_valid = '0;
        while ((busy || req_ready != {NUM_REQ{1'b1}}) && g < 500) begin
            cycle();
            g++;
        end
        check({tag, "_idle"}, {busy, req_ready}, {1'b0, {NUM_REQ{1'b1}}});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int ev0;
        int caps;
        int rr_exp [6];
        rr_exp = '{0, 1, 3, 0, 2, 0};

        rst_n                 = 1'b0;
        req_valid             = '0;
        req_interrupter_index = '0;
        req_trb_data          = '0;
        lat_min = 0; lat_max = 3; hold_min = 1; hold_max = 4; hang = 1'b0;
        engine_reset();
        model_reset();
        repeat (3) @(negedge clk_pcie);
        check("rst_req_ready", req_ready, {NUM_REQ{1'b1}});
        check("rst_req_done", req_done, '0);
        check("rst_eng_send", eng_send, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall_err, 1'b0);
        check("rst_events", events_issued, '0);
        check("rst_trb", eng_trb_data, '0);
        rst_n = 1'b1;

        // Single request from producer 1, engine completes ~10 cycles later.
        lat_min = 9; lat_max = 9; hold_min = 1; hold_max = 1;
        done_log.delete();
        cycle();
        req_valid = 4'b0010;
        req_interrupter_index[3 +: 3] = 3'd2;
        req_trb_data[128 +: 128]      = {16{8'hA5}};
        cycle();
        req_valid = '0;
        g = 0;
        while (done_log.size() == 0 && g < 40) begin
            cycle();
            g++;
        end
        check("single_done_count", done_log.size(), 1);
        check("single_done_port", (done_log.size() > 0) ? done_log[0] : -1, 1);
        check("single_events", events_issued, 1);
        check("single_ready1", req_ready[1], 1'b1);
        drain("single");

        // Round-robin 0,1,3 then refill 0 during grant 3, then rr check.
        apply_reset();
        lat_min = 1; lat_max = 3; hold_min = 1; hold_max = 2;
        done_log.delete();
        cycle();
        req_valid = 4'b1011;
        for (int i = 0; i < NUM_REQ; i++) rand_data(i);
        cycle();
        req_valid = '0;
        g = 0;
        while (!(done_log.size() >= 2 && eng_send) && g < 100) begin
            cycle();
            g++;
        end
        req_valid = 4'b0001;
        rand_data(0);
        cycle();
        drain("rr1");
        req_valid = 4'b0101;
        rand_data(0);
        rand_data(2);
        cycle();
        drain("rr2");
        check("rr_count", done_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check("rr_order", (k < done_log.size()) ? done_log[k] : -1, rr_exp[k]);
        end

        // Back-to-back on producer 2, refilled as soon as it frees.
        apply_reset();
        lat_min = 0; lat_max = 2; hold_min = 1; hold_max = 3;
        caps = 0;
        g    = 0;
        while ((caps < 5 || busy || !req_ready[2]) && g < 300) begin
            if (caps < 5 && req_ready[2]) begin
                req_valid = 4'b0100;
                rand_data(2);
                caps++;
            end else begin
                req_valid = '0;
            end
            cycle();
            g++;
        end
        check("b2b_events", events_issued, 5);
        drain("b2b");

        // Random traffic.
        lat_min = 0; lat_max = 3; hold_min = 1; hold_max = 4;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = ($urandom_range(2, 0) == 0);
                rand_data(i);
            end
            cycle();
        end
        drain("random");

        // Completion held for 4 cycles with every slot full.
        hold_min = 4; hold_max = 4;
        ev0 = int'(events_issued);
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) rand_data(i);
        cycle();
        drain("hold");
        check("hold_events", events_issued, 32'(ev0 + 4));

        // Timeout: engine never completes until released late.
        apply_reset();
        hold_min = 1; hold_max = 2;
        hang = 1'b1;
        req_valid = 4'b1000;
        rand_data(3);
        cycle();
        req_valid = '0;
        g = 0;
        while (!eng_send && g < 20) begin
            cycle();
            g++;
        end
        check("tmo_send", eng_send, 1'b1);
        repeat (TMO - 1) cycle();
        check("tmo_before", stall_err, 1'b0);
        cycle();
        check("tmo_at", stall_err, 1'b1);
        repeat (10) cycle();
        hang = 1'b0;
        drain("tmo");
        check("tmo_sticky", stall_err, 1'b1);
        check("tmo_events", events_issued, 1);

        // Reset while waiting for completion.
        apply_reset();
        hang = 1'b1;
        req_valid = 4'b0001;
        rand_data(0);
        cycle();
        req_valid = '0;
        g = 0;
        while (!eng_send && g < 20) begin
            cycle();
            g++;
        end
        repeat (3) cycle();
        check("mid_send_before", eng_send, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_eng_send", eng_send, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_ready", req_ready, {NUM_REQ{1'b1}});
        check("mid_done", req_done, '0);
        hang = 1'b0;
        done_log.delete();
        apply_reset();
        repeat (10) cycle();
        check("mid_no_done", done_log.size(), 0);
        check("mid_events", events_issued, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
